// File: rtl/apb_master_ctrl_if.sv
// apb_master_ctrl_if: command, APB and response signals of the APB master controller
interface apb_master_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_write;
  logic [DATA_W-1:0] cmd_wdata;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, pready, pslverr, prdata, rsp_ready,
    output cmd_ready, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, pready, pslverr, prdata, rsp_ready,
    input  cmd_ready, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-outstanding command to APB master with address policy and pready timeout
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic                pclk,
  input logic                preset,
  apb_master_ctrl_if.master  bus
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, rsp_timeout_q, rsp_timeout_d;
  logic              ro, wo, illegal;
  assign ro      = bus.cmd_addr == ADDR_W'(3) || bus.cmd_addr == ADDR_W'(5);
  assign wo      = bus.cmd_addr == ADDR_W'(2) || bus.cmd_addr == ADDR_W'(4) || bus.cmd_addr == ADDR_W'(6);
  assign illegal = bus.cmd_write ? ro : wo;
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        paddr_d       = bus.cmd_addr;
        pwrite_d      = bus.cmd_write;
        pwdata_d      = bus.cmd_wdata;
        state_d       = illegal ? RESP : SETUP;
        psel_d        = !illegal;
        rsp_valid_d   = illegal;
        rsp_err_d     = illegal;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = '0;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        // pready wins over the timeout limit on the same cycle
        if (bus.pready || cnt_q == CW'(TIMEOUT - 1)) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = !bus.pready;
          rsp_err_d     = bus.pready ? bus.pslverr : 1'b1;
          rsp_rdata_d   = (bus.pready && !pwrite_q) ? bus.prdata : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: if (bus.rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.cmd_ready   = state_q == IDLE;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed and random transactions checked against a transaction-level model
module tb_apb_master_ctrl;
  localparam int TIMEOUT = 16;
  logic pclk = 1'b0;
  logic preset;
  int n_cmp = 0;
  int n_bad = 0;
  apb_master_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();
  apb_master_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (.pclk(pclk), .preset(preset), .bus(bus));
  always #5 pclk = ~pclk;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_psel"}, int'(bus.psel), 0);
    chk({tag, "_penable"}, int'(bus.penable), 0);
    chk({tag, "_pwrite"}, int'(bus.pwrite), 0);
    chk({tag, "_paddr"}, int'(bus.paddr), 0);
    chk({tag, "_pwdata"}, int'(bus.pwdata), 0);
    chk({tag, "_rsp_valid"}, int'(bus.rsp_valid), 0);
    chk({tag, "_rsp_rdata"}, int'(bus.rsp_rdata), 0);
    chk({tag, "_rsp_err"}, int'(bus.rsp_err), 0);
    chk({tag, "_rsp_timeout"}, int'(bus.rsp_timeout), 0);
    chk({tag, "_cmd_ready"}, int'(bus.cmd_ready), 1);
  endtask
  // One command end to end; the slave completes after `waits` wait cycles (never if waits >= TIMEOUT)
  task automatic txn(input logic [7:0] a, input logic w, input logic [7:0] wd, input int waits,
                     input logic se, input logic [7:0] rd, input int hold);
    bit ill = w ? (a == 3 || a == 5) : (a == 2 || a == 4 || a == 6);
    bit to = !ill && waits >= TIMEOUT;
    int acc_exp = ill ? 0 : (to ? TIMEOUT : waits + 1);
    int lat_exp = ill ? 1 : acc_exp + 2;
    int exp_err = (ill || to) ? 1 : int'(se);
    int exp_rd = (ill || to || w) ? 0 : int'(rd);
    int setup_n = 0, acc_n = 0, sel_at = 0, en_at = 0, cyc = 0, bad = 0;
    chk("cmd_ready_before", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_write = w;
    bus.cmd_wdata = wd;
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_write = 1'($urandom);
    bus.cmd_wdata = 8'($urandom);
    for (int i = 0; i < 60; i++) begin
      @(negedge pclk);
      cyc++;
      if (bus.rsp_valid) break;
      if (bus.cmd_ready) bad++;
      if (bus.penable && !bus.psel) bad++;
      if (bus.psel && (bus.paddr != a || bus.pwrite != w || bus.pwdata != wd)) bad++;
      if (bus.psel && !bus.penable) begin
        setup_n++;
        if (sel_at == 0) sel_at = cyc;
      end
      if (bus.psel && bus.penable) begin
        if (en_at == 0) en_at = cyc;
        bus.pready = (acc_n == waits);
        bus.prdata = bus.pready ? rd : 8'($urandom);
        bus.pslverr = bus.pready ? se : 1'($urandom);
        acc_n++;
      end else begin
        bus.pready = 1'b0;
        bus.prdata = 8'($urandom);
        bus.pslverr = 1'($urandom);
      end
    end
    bus.pready = 1'b0;
    chk("latency", cyc, lat_exp);
    chk("setup_cycles", setup_n, ill ? 0 : 1);
    chk("access_cycles", acc_n, acc_exp);
    chk("protocol_violations", bad, 0);
    if (!ill) begin
      chk("psel_first_cycle", sel_at, 1);
      chk("penable_first_cycle", en_at, 2);
    end
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge pclk);
      chk("rsp_valid", int'(bus.rsp_valid), 1);
      chk("rsp_err", int'(bus.rsp_err), exp_err);
      chk("rsp_timeout", int'(bus.rsp_timeout), int'(to));
      chk("rsp_rdata", int'(bus.rsp_rdata), exp_rd);
      chk("psel_in_resp", int'(bus.psel), 0);
      chk("cmd_ready_in_resp", int'(bus.cmd_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge pclk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge pclk);
    chk("rsp_valid_after", int'(bus.rsp_valid), 0);
    chk("cmd_ready_after", int'(bus.cmd_ready), 1);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    bus.rsp_ready = 1'b0;
    preset = 1'b1;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    chk_idle_outputs("reset");
    preset = 1'b0;
    @(negedge pclk);
    txn(8'd2, 1'b1, 8'h5A, 0, 1'b0, 8'h99, 0);
    txn(8'd5, 1'b0, 8'h11, 3, 1'b0, 8'hC3, 0);
    txn(8'd4, 1'b0, 8'h22, 0, 1'b0, 8'h77, 1);
    txn(8'd3, 1'b1, 8'h33, 0, 1'b0, 8'h77, 1);
    txn(8'd3, 1'b0, 8'h44, 1000, 1'b1, 8'hEE, 0);
    txn(8'd6, 1'b1, 8'hA5, 1, 1'b1, 8'h66, 4);
    txn(8'd9, 1'b0, 8'h00, TIMEOUT - 1, 1'b0, 8'h3C, 0);
    // abort mid-ACCESS with reset
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 8'd7;
    bus.cmd_write = 1'b1;
    bus.cmd_wdata = 8'hF0;
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (2) @(negedge pclk);
    chk("mid_access_psel", int'(bus.psel), 1);
    chk("mid_access_penable", int'(bus.penable), 1);
    preset = 1'b1;
    @(posedge pclk);
    #1;
    preset = 1'b0;
    @(negedge pclk);
    chk_idle_outputs("abort");
    repeat (3) @(negedge pclk);
    chk("abort_no_rsp", int'(bus.rsp_valid), 0);
    chk("abort_cmd_ready", int'(bus.cmd_ready), 1);
    for (int k = 0; k < 60; k++) begin
      int r = int'($urandom_range(0, 9));
      txn(8'($urandom_range(0, 9)), 1'($urandom), 8'($urandom),
          r < 7 ? int'($urandom_range(0, 5)) : int'($urandom_range(TIMEOUT - 2, TIMEOUT + 4)),
          1'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning APB data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of ACCESS cycles spent waiting for pready.
REQ-004 The block SHALL have port pclk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 The block SHALL have port preset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit: a command is accepted this cycle.
REQ-008 The block SHALL have port cmd_addr, input, ADDR_W bits: the target register.
REQ-009 The block SHALL have port cmd_write, input, 1 bit: 1 means write, 0 means read.
REQ-010 The block SHALL have port cmd_wdata, input, DATA_W bits: the write data.
REQ-011 The block SHALL have ports psel, penable and pwrite, outputs, 1 bit each: APB control.
REQ-012 The block SHALL have port paddr, output, ADDR_W bits, and port pwdata, output, DATA_W bits.
REQ-013 The block SHALL have port pready, input, 1 bit; port pslverr, input, 1 bit; and port prdata, input, DATA_W bits.
REQ-014 The block SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-015 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
REQ-016 The block SHALL have port rsp_rdata, output, DATA_W bits: read data, zero for writes and errors.
REQ-017 The block SHALL have port rsp_err, output, 1 bit, and port rsp_timeout, output, 1 bit: the error flags.

Function
REQ-018 The block SHALL implement states IDLE, SETUP, ACCESS and RESP; all outputs SHALL be registered, except cmd_ready, which SHALL equal (state==IDLE).
REQ-019 On cmd_valid & cmd_ready, the block SHALL latch cmd_addr, cmd_write and cmd_wdata.
REQ-020 Address policy: addresses 2, 4 and 6 SHALL be write-only, and addresses 3 and 5 SHALL be read-only; any other address SHALL be accepted in either direction.
REQ-021 An illegal command (a read to 2/4/6 or a write to 3/5) SHALL go IDLE->RESP with rsp_err=1, rsp_rdata=0 and no APB activity; psel SHALL stay 0.
REQ-022 A legal command SHALL go IDLE->SETUP; the next cycle psel=1, penable=0, and paddr, pwrite and pwdata SHALL equal the latched values.
REQ-023 SETUP SHALL always advance to ACCESS after one cycle; in ACCESS psel=1 and penable=1.
REQ-024 paddr, pwrite and pwdata SHALL be held stable from SETUP through the final ACCESS cycle.
REQ-025 In ACCESS, the block SHALL sample pready on each edge; when pready=1 it SHALL go to RESP, drop psel and penable to 0, capture prdata into rsp_rdata for reads (0 for writes), and set rsp_err=pslverr.
REQ-026 The wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-027 When the wait count reaches TIMEOUT-1 with pready still 0, the block SHALL go to RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0; psel and penable SHALL drop to 0.
REQ-028 pready=1 on the same cycle as the timeout limit SHALL be treated as a completion, not a timeout.
REQ-029 Zero-wait latency SHALL be: accept at edge N; SETUP at N+1; ACCESS at N+2 with pready sampled; rsp_valid=1 at N+3.
REQ-030 In RESP, rsp_valid=1 and the response fields SHALL be held until rsp_valid & rsp_ready; the block SHALL then return to IDLE with rsp_valid=0 and cmd_ready=1 the following cycle.
REQ-031 There SHALL be one outstanding command; cmd_ready=0 in SETUP, ACCESS and RESP.
REQ-032 pslverr and prdata SHALL be ignored outside the completing ACCESS cycle.
REQ-033 penable=1 SHALL never occur without psel=1, and psel=1 with penable=0 SHALL last exactly one cycle per transfer.

Reset
REQ-034 When preset=1 at a rising edge, the block SHALL go to IDLE and set psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout and the wait counter to 0.
REQ-035 A reset in any state, including mid-ACCESS, SHALL abort the transfer with no response generated; cmd_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-036 The bench SHALL check: write addr 2 data 0x5A, pready=1 immediately -> psel at N+1, penable at N+2, rsp_valid at N+3 with rsp_err=0 and rsp_rdata=0.
REQ-037 The bench SHALL check: read addr 5, pready after 3 wait cycles, prdata=0xC3 -> rsp_rdata=0xC3, rsp_err=0, with paddr and pwrite stable throughout.
REQ-038 The bench SHALL check: read addr 4 -> rsp_valid with rsp_err=1, psel never asserted, and write addr 3 behaves the same.
REQ-039 The bench SHALL check: read addr 3 with pready held 0 -> rsp_timeout=1 and rsp_err=1 after 16 ACCESS cycles, then psel=0.
REQ-040 The bench SHALL check: write addr 6 with pslverr=1 at completion -> rsp_err=1 and rsp_timeout=0; rsp_ready held 0 for 4 cycles keeps the response stable.
REQ-041 The bench SHALL check: preset=1 during ACCESS -> next cycle all outputs are 0, no rsp_valid, and cmd_ready=1 after release.
